// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and nibble width.
package nsa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NIB_BITS = 4;

endpackage

// File: rtl/rippleCarryAdder.sv
// 4-bit ripple-carry adder, the nibble datapath of the serial adder.
// Purely combinational; no latency, no flow control.
module rippleCarryAdder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       Cy_in,
    output logic [3:0] sum,
    output logic       Cy4
);

    logic [4:0] c;

    assign c[0] = Cy_in;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign Cy4 = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word adder computing a + b + cin one nibble per clock through rippleCarryAdder.
// Latency: out_valid rises WIDTH/4 clocks after the accept edge; one op per WIDTH/4+2 cycles.
// Backpressure: result held in DONE until out_ready; no new operands accepted meanwhile.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIB_BITS;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH < NIB_BITS) || ((WIDTH % NIB_BITS) != 0)) begin : g_width_chk
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       nib_sum;
    logic             nib_cy;

    rippleCarryAdder u_rca (
        .a     (a_sh[3:0]),
        .b     (b_sh[3:0]),
        .Cy_in (carry),
        .sum   (nib_sum),
        .Cy4   (nib_cy)
    );

    // Each new nibble enters at the top, so after NIB steps nibble 0 sits at the bottom.
    if (NIB == 1) begin : g_one_nib
        assign result_nxt = nib_sum;
    end else begin : g_multi_nib
        assign result_nxt = {nib_sum, result[WIDTH-1:NIB_BITS]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            result <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    result <= result_nxt;
                    carry  <= nib_cy;
                    a_sh   <= a_sh >> NIB_BITS;
                    b_sh   <= b_sh >> NIB_BITS;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NIB - 1)) begin
                        sum   <= result_nxt;
                        cout  <= nib_cy;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_ADD);
    assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16 and WIDTH=4 instances).
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    // WIDTH=16 instance
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [15:0] a, b, sum;

    // WIDTH=4 instance
    logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
    logic [3:0]  a4, b4, sum4;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain (WIDTH+1)-bit arithmetic.
    function automatic logic [16:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {16'b0, c};
    endfunction

    task automatic op16(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input bit hold_result);
        logic [16:0] exp;
        int n;
        exp = ref16(ta, tb_v, tc);
        check("in_ready_before_accept", in_ready, 1);
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        check("busy_after_accept", busy, 1);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("latency16", n, 4);
        check("sum16", sum, exp[15:0]);
        check("cout16", cout, exp[16]);
        if (!hold_result) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("idle_after_done", in_ready, 1);
        end
    endtask

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc);
        logic [4:0] exp;
        int n;
        exp = {1'b0, ta} + {1'b0, tb_v} + {4'b0, tc};
        a4 = ta; b4 = tb_v; cin4 = tc; in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        a4 = 4'($urandom);
        n = 0;
        while (out_valid4 !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("latency4", n, 1);
        check("sum4", sum4, exp[3:0]);
        check("cout4", cout4, exp[4]);
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
    endtask

    initial begin
        logic [15:0] hs;
        logic        hc;
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] e;
        int          last;
        int          n;

        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0;
        in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0; cin4 = 0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst_n = 1'b1;
        tick();

        op16(16'h1234, 16'h4321, 1'b0, 0);
        op16(16'hFFFF, 16'h0001, 1'b0, 0);
        op16(16'hFFFF, 16'hFFFF, 1'b1, 0);

        // Result held under backpressure while new operands are offered
        op16(16'hA5A5, 16'h1357, 1'b1, 1);
        hs = sum; hc = cout;
        e = ref16(16'hA5A5, 16'h1357, 1'b1);
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_sum", sum, e[15:0]);
            check("bp_cout", cout, e[16]);
        end
        check("bp_sum_stable", sum, hs);
        check("bp_cout_stable", cout, hc);
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", in_ready, 1);
        check("bp_no_capture", busy, 0);
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        check("bp_still_idle", in_ready, 1);

        // Asynchronous reset in the middle of ADD
        a = 16'h0F0F; b = 16'h7777; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_in_ready", in_ready, 1);
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_no_result", out_valid, 0);
        op16(16'h000F, 16'h0001, 1'b0, 0);

        // WIDTH=4 build
        op4(4'hF, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) op4(4'($urandom), 4'($urandom), 1'($urandom));

        // Random single operations
        for (int i = 0; i < 6; i++) op16(16'($urandom), 16'($urandom), 1'($urandom), 0);

        // Back-to-back with in_valid and out_ready held high
        in_valid = 1'b1; out_ready = 1'b1;
        last = -1;
        for (int k = 0; k < 3; k++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            e = ref16(ra, rb, rc);
            a = ra; b = rb; cin = rc;
            check("b2b_in_ready", in_ready, 1);
            tick();
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            n = 0;
            while (out_valid !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            check("b2b_latency", n, 4);
            check("b2b_sum", sum, e[15:0]);
            check("b2b_cout", cout, e[16]);
            if (last >= 0) check("b2b_spacing", cyc - last, 6);
            last = cyc;
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid === 1'b1 || busy === 1'b1) n++;
        end
        check("b2b_no_extra_op", n, 0);
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-word adder stage wrapped around the team's existing 4-bit ripple-carry adder (rippleCarryAdder). It accepts WIDTH-bit operands over a valid/ready handshake and computes the sum one nibble per clock, chaining the carry across cycles through a register. It returns the WIDTH-bit sum plus carry-out over a second valid/ready handshake. It sits directly downstream of operand producers and directly upstream of the 4-bit adder, which it drives.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
NIB, WIDTH/4, derived nibble count; not overridable

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  reset
in_valid  input  1  operands a, b, cin valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in to nibble 0
out_valid  output  1  sum/cout valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  registered result
cout  output  1  carry-out of top nibble
busy  output  1  high in ADD state

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, sum=0, cout=0, out_valid=0, busy=0, internal shift regs/carry/counter=0. in_ready=1 (decoded from IDLE).
- FSM has three states: IDLE, ADD, DONE. Outputs are decoded from the state: in_ready=(IDLE), busy=(ADD), out_valid=(DONE).
- IDLE:
  - in_valid=1 accepts the transfer on that edge.
  - Captures a_sh<=a, b_sh<=b, carry<=cin, cnt<=0.
  - Next state is ADD.
- ADD, every cycle:
  - Adder inputs: a=a_sh[3:0], b=b_sh[3:0], Cy_in=carry.
  - Updates on the edge: result<={adder.sum, result[WIDTH-1:4]}; carry<=adder.Cy4; a_sh>>=4; b_sh>>=4; cnt<=cnt+1.
  - When cnt==NIB-1: sum<=final shifted result, cout<=adder.Cy4, next state is DONE.
- DONE:
  - sum and cout are held stable.
  - in_valid is ignored (in_ready=0).
  - out_ready=1 completes the transfer; next state is IDLE.
- Latency: out_valid rises exactly NIB clocks after the accept edge. Throughput is one operation per NIB+2 cycles minimum; there is no overlap between result hold and new accept.
- Arithmetic: {cout,sum} = a + b + cin modulo 2^(WIDTH+1). Nibble 0 is processed first.
- cnt width is max(1,$clog2(NIB)). For WIDTH=4 the ADD state lasts exactly one cycle.
- sum holds its previous value from DONE through IDLE and ADD; it updates only on the final ADD edge. Consumers sample it only with out_valid.
- Boundary conditions:
  - in_valid held high in ADD/DONE: no effect, no second capture.
  - in_valid and out_ready both high in DONE: result completes; operands are not captured that cycle.
  - rst_n low mid-ADD or mid-DONE: immediate return to IDLE, all reset values apply, the partial result is discarded and no out_valid is produced.
  - Operand changes after the accept edge do not affect the result.

Decomposition:
- Shared package nsa_pkg: state encoding constants ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2; NIB_BITS=4.
- One sub-module instance: the existing rippleCarryAdder (ports a, b, Cy_in, sum, Cy4), used unmodified as the nibble datapath.
- FSM, shift registers and carry register stay in nibble_serial_adder.

Test Plan:
1. WIDTH=16, a=16'h1234, b=16'h4321, cin=0 -> out_valid 4 clocks after accept; sum=16'h5555, cout=0.
2. WIDTH=16, a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1. Also a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1 (carry ripples across all 4 nibbles).
3. Backpressure: out_ready=0 for 6 cycles in DONE with in_valid=1 and changing a/b -> sum/cout/out_valid stable, in_ready=0, no capture. out_ready=1 -> IDLE next edge, in_ready=1.
4. Reset mid-operation: assert rst_n=0 asynchronously at cnt=2 -> out_valid=0, busy=0, sum=0, in_ready=1 immediately. After release, a new op a=16'h000F, b=16'h0001 -> sum=16'h0010.
5. WIDTH=4 build: a=4'hF, b=4'hF, cin=0 -> sum=4'hE, cout=1, out_valid 1 clock after accept.
6. Back-to-back: in_valid held high with 3 operand pairs, out_ready=1 -> exactly 3 results in order, each spaced NIB+2 cycles, randomized checks against a+b+cin.
